// File: rtl/alu_operand_queue.sv
// ALU operand selector feeding a DEPTH-entry FIFO toward the EX stage.
// Optional build macro ALU_OPQ_FWD_EN adds fwd_valid/fwd_data forwarding ports.
module alu_operand_queue #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 4,
  parameter int SELW  = 2,
  parameter int DEPTH = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SELW-1:0]           sel,
  input  logic [NSRC*WIDTH-1:0]     src,
`ifdef ALU_OPQ_FWD_EN
  input  logic                      fwd_valid,
  input  logic [WIDTH-1:0]          fwd_data,
`endif
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_sel_err,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [SELW:0] NSRC_W = (SELW+1)'(NSRC);
  localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);

  logic [WIDTH-1:0] mem_data [DEPTH];
  logic [DEPTH-1:0] mem_err;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] sel_data;
  logic             sel_oor;
  logic [WIDTH-1:0] entry_data;
  logic             entry_err;

  // Handshake: a transfer happens on a side only in a cycle where both its
  // valid and ready are high at the rising edge; ready/valid here come from
  // registered occupancy only, so neither side combinationally depends on the other.
  assign in_ready  = (count_q != DEPTH_W);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (sel == SELW'(k)) sel_data = src[k*WIDTH +: WIDTH];
    end
  end

  assign sel_oor = ({1'b0, sel} >= NSRC_W);

`ifdef ALU_OPQ_FWD_EN
  // Forwarded data overrides the selection and is never flagged as bad select.
  assign entry_data = fwd_valid ? fwd_data : sel_data;
  assign entry_err  = !fwd_valid && sel_oor;
`else
  assign entry_data = sel_data;
  assign entry_err  = sel_oor;
`endif

  assign out_data    = mem_data[rd_ptr];
  assign out_sel_err = mem_err[rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      mem_err <= '0;
      for (int i = 0; i < DEPTH; i++) mem_data[i] <= '0;
    end else if (flush) begin
      // Storage is left as-is; only the bookkeeping is cleared.
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= sel_oor && !entry_err ? entry_data : (entry_err ? '0 : entry_data);
        mem_err[wr_ptr]  <= entry_err;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_queue.sv
// Self-checking bench for alu_operand_queue: queue-based reference model plus
// a decoupled monitor; build with ALU_OPQ_FWD_EN to exercise forwarding.
module tb_alu_operand_queue;
  localparam int WIDTH = 32;
  localparam int NSRC  = 3;
  localparam int SELW  = 2;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                  clock;
  logic                  reset_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [SELW-1:0]       sel;
  logic [NSRC*WIDTH-1:0] src;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic                  out_sel_err;
  logic [CW-1:0]         count;
`ifdef ALU_OPQ_FWD_EN
  logic                  fwd_valid;
  logic [WIDTH-1:0]      fwd_data;
`endif

  logic [WIDTH-1:0] src_w [NSRC];
  logic [WIDTH:0]   exp_q [$];
  int               mdl_count;
  bit               seen_reset;
  bit               just_reset;
  int               n_vec;
  int               n_err;

  alu_operand_queue #(.WIDTH(WIDTH), .NSRC(NSRC), .SELW(SELW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .src(src),
`ifdef ALU_OPQ_FWD_EN
    .fwd_valid(fwd_valid), .fwd_data(fwd_data),
`endif
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel_err(out_sel_err), .count(count)
  );

  // Clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always_comb begin
    src = '0;
    for (int k = 0; k < NSRC; k++) src[k*WIDTH +: WIDTH] = src_w[k];
  end

  // Reference entry: {err, data}
  function automatic logic [WIDTH:0] ref_entry();
    int s;
    s = int'(sel);
`ifdef ALU_OPQ_FWD_EN
    if (fwd_valid) return {1'b0, fwd_data};
`endif
    if (s < NSRC) return {1'b0, src_w[s]};
    return {1'b1, {WIDTH{1'b0}}};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advances at each edge from the pre-edge inputs
  always @(posedge clock) begin
    bit do_push;
    bit do_pop;
    do_pop  = out_ready && (mdl_count > 0);
    do_push = in_valid && (mdl_count < DEPTH);
    if (!reset_n) begin
      exp_q.delete();
      mdl_count  = 0;
      seen_reset = 1'b1;
      just_reset = 1'b1;
    end else if (flush) begin
      exp_q.delete();
      mdl_count  = 0;
      just_reset = 1'b0;
    end else begin
      if (do_push) exp_q.push_back(ref_entry());
      mdl_count  = mdl_count + int'(do_push) - int'(do_pop);
      just_reset = 1'b0;
    end
  end

  // Monitor: checks status every cycle and pops the scoreboard on each transfer
  always @(negedge clock) begin
    logic [WIDTH:0] e;
    if (seen_reset) begin
      check("count", 64'(count), 64'(mdl_count));
      check("out_valid", 64'(out_valid), 64'(mdl_count != 0));
      check("in_ready", 64'(in_ready), 64'(mdl_count < DEPTH));
      if (just_reset) begin
        check("reset_out_data", 64'(out_data), 64'd0);
        check("reset_out_sel_err", 64'(out_sel_err), 64'd0);
      end
      if (reset_n && !flush && out_ready && mdl_count > 0) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL scoreboard_underflow: got empty queue expected an entry");
        end else begin
          e = exp_q.pop_front();
          check("out_data", 64'(out_data), 64'(e[WIDTH-1:0]));
          check("out_sel_err", 64'(out_sel_err), 64'(e[WIDTH]));
        end
      end
    end
  end

  // Driver tasks
  task automatic rand_src();
    for (int k = 0; k < NSRC; k++) src_w[k] = $urandom;
  endtask

  task automatic step(input bit rn, input bit iv, input logic [SELW-1:0] s,
                      input bit ordy, input bit fl);
    reset_n   = rn;
    in_valid  = iv;
    sel       = s;
    out_ready = ordy;
    flush     = fl;
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    mdl_count = 0;
    reset_n = 1'b0; in_valid = 1'b0; sel = '0; flush = 1'b0; out_ready = 1'b0;
`ifdef ALU_OPQ_FWD_EN
    fwd_valid = 1'b0; fwd_data = '0;
`endif
    rand_src();
    step(0, 1, 1, 1, 0);
    step(0, 1, 1, 1, 0);

    // Single push, one-cycle latency
    src_w[1] = 32'h0000_0092;
    step(1, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);

    // Fill, refused third push with simultaneous pop, drain in order
    src_w[0] = 32'h7B; step(1, 1, 0, 0, 0);
    src_w[0] = 32'h99; step(1, 1, 0, 0, 0);
    src_w[0] = 32'h55; step(1, 1, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);

    // Streaming
    for (int i = 0; i < 10; i++) begin
      rand_src();
      step(1, 1, SELW'($urandom_range(0, NSRC-1)), 1, 0);
    end
    step(1, 0, 0, 1, 0);

    // Out-of-range select between valid entries
    rand_src(); step(1, 1, 0, 1, 0);
    rand_src(); step(1, 1, 3, 1, 0);
    rand_src(); step(1, 1, 2, 1, 0);
    step(1, 0, 0, 1, 0);

    // Flush with full queue and a concurrent push
    rand_src(); step(1, 1, 0, 0, 0);
    rand_src(); step(1, 1, 1, 0, 0);
    rand_src(); step(1, 1, 2, 1, 1);
    step(1, 0, 0, 0, 0);

    // Same with reset
    rand_src(); step(1, 1, 0, 0, 0);
    rand_src(); step(1, 1, 1, 0, 0);
    rand_src(); step(0, 1, 2, 1, 0);
    step(1, 0, 0, 0, 0);

`ifdef ALU_OPQ_FWD_EN
    fwd_valid = 1'b1; fwd_data = 32'hDEAD_BEEF;
    rand_src(); step(1, 1, 3, 1, 0);
    fwd_valid = 1'b0;
    step(1, 0, 0, 1, 0);
`endif

    // Randomized traffic with back-pressure and occasional flush
    for (int i = 0; i < 400; i++) begin
      rand_src();
`ifdef ALU_OPQ_FWD_EN
      fwd_valid = ($urandom_range(0, 3) == 0);
      fwd_data  = $urandom;
`endif
      step(1, bit'($urandom_range(0, 1)), SELW'($urandom_range(0, 3)),
           bit'($urandom_range(0, 1)), ($urandom_range(0, 29) == 0));
    end
`ifdef ALU_OPQ_FWD_EN
    fwd_valid = 1'b0;
`endif
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_operand_queue.md
# alu_operand_queue

Parametrised ALU operand selector with a buffered output stage for the pipelined datapath. Each accepted transaction selects one of NSRC WIDTH-bit sources: register read data, extended immediate, shift amount, or constant. The selected operand is pushed into a DEPTH-entry FIFO and presented to the ALU/EX stage through a valid/ready handshake. Compared with the single-cycle 2:1 operand mux, it adds N-way selection, registered buffering, back-pressure, flush and out-of-range select detection.

## Interface
- WIDTH, 32, operand width in bits
- NSRC, 4, number of selectable sources (2..16)
- SELW, 2, select width; must satisfy 2**SELW >= NSRC
- DEPTH, 2, FIFO entries; power of two, 2..16
- clock  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clock
- in_valid  input  1  upstream has a transaction
- in_ready  output  1  queue can accept; equals !full
- sel  input  SELW  source index, sampled on accept
- src  input  NSRC*WIDTH  flattened sources; source k = src[k*WIDTH +: WIDTH]
- flush  input  1  discard all queued entries (branch/exception)
- out_valid  output  1  head entry present; equals !empty
- out_ready  input  1  downstream consumes head when out_valid is also high
- out_data  output  WIDTH  head operand
- out_sel_err  output  1  head entry was written with sel >= NSRC
- count  output  $clog2(DEPTH)+1  occupancy

## Operation
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- On push: entry = {sel >= NSRC, (sel < NSRC) ? src[sel] : 0}, written at wr_ptr. wr_ptr advances modulo DEPTH.
- On pop: rd_ptr advances modulo DEPTH.
- count updates as +1 (push only), -1 (pop only), or unchanged (both or neither).
- Full (count == DEPTH): in_ready = 0. in_ready does not depend combinationally on out_ready, so a push is refused even when a pop happens in the same cycle.
- Empty: out_valid = 0, so no pop occurs. out_data and out_sel_err show the stale entry at rd_ptr and are don't-care.
- Same-cycle push and pop with 0 < count < DEPTH: both take effect, and count is unchanged.
- Flush: at the next edge, count = 0 and wr_ptr = rd_ptr = 0. Flush has priority over push and pop in the same cycle; that cycle's input is discarded and not stored. in_ready is 1 in the following cycle.
- Out-of-range sel is not an error to upstream. The entry stores data 0 with the err bit set, travels in order, and is popped normally.
- Select arithmetic is unsigned. No sign or zero extension happens here; sources arrive already WIDTH bits wide.

## Timing
- Reset (reset_n = 0 at an edge): count = 0, pointers = 0, all storage = 0. Resulting outputs: out_valid = 0, in_ready = 1, out_data = 0, out_sel_err = 0. A push in a reset cycle is ignored. Reset mid-stream drops all entries.
- Latency: a push at edge N gives out_valid = 1 with out_data = the selected source after edge N. There is no combinational path from src/sel to out_data.
- Throughput: one push and one pop per cycle sustained.
- out_data and out_sel_err hold stable while out_valid = 1 and out_ready = 0.
- in_ready, out_valid and count are derived from registers only.

## Configuration
- ALU_OPQ_FWD_EN defined: adds ports fwd_valid (input, 1) and fwd_data (input, WIDTH). On push with fwd_valid = 1, the entry stores fwd_data in place of the selected source, and the err bit is forced to 0 regardless of sel. This covers EX/MEM forwarding ahead of the queue.
- ALU_OPQ_FWD_EN undefined: the ports are absent and selection is purely sel-driven.

## Test plan
- Reset, then single push with NSRC=4, sel=1, src1=0x00000092 -> after the following edge out_valid=1, out_data=0x00000092, out_sel_err=0, count=1.
- Fill with DEPTH=2 and out_ready=0: push 0x7B then 0x99 -> in_ready=0, count=2. A third push, also driven with out_ready=1 in the same cycle, is refused. Then drain in FIFO order 0x7B, 0x99; out_valid=0 after the second pop.
- Continuous in_valid=out_ready=1 for 10 cycles, sources and sel varied per cycle -> count stays 1 and outputs match the stimulus exactly, delayed by 1 cycle.
- NSRC=3, sel=3 -> entry with out_data=0, out_sel_err=1, delivered in order between valid entries.
- Flush with count=2 while in_valid=1 -> next cycle count=0, out_valid=0, the flush-cycle input absent. Repeat the same check with reset_n=0 instead of flush; outputs must equal the reset values.
- ALU_OPQ_FWD_EN build, fwd_valid=1, fwd_data=0xDEADBEEF, sel=3, NSRC=3 -> out_data=0xDEADBEEF, out_sel_err=0.
